// File: rtl/pow_seq.sv
// pow_seq: sequential unsigned power unit (square-and-multiply).
//
// Accepts an operand pair (p, q) and produces p**q mod 2^OUT_W after
// exactly EXP_W iterations. The run length does not depend on q.
//
// Ports:
//   clk            - clock, all state updates on the rising edge
//   rst            - synchronous active-high reset
//   data_in        - base p (DATA_W bits, unsigned)
//   exp_in         - exponent q (EXP_W bits, unsigned)
//   data_in_valid  - operand pair offered
//   data_in_ready  - high in IDLE only
//   data_out       - result while data_out_valid is high, zero otherwise
//   data_out_valid - result held until data_out_ready
//   data_out_ready - consumer accepts the result
//   ovf            - true result >= 2^OUT_W (only when POW_OVF_EN is defined)
//
// Build option: define POW_OVF_EN to add the ovf port and overflow tracking.
module pow_seq #(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned EXP_W  = 4,
    parameter int unsigned OUT_W  = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] data_in,
    input  logic [EXP_W-1:0]  exp_in,
    input  logic              data_in_valid,
    output logic              data_in_ready,
    output logic [OUT_W-1:0]  data_out,
    output logic              data_out_valid,
    input  logic              data_out_ready
`ifdef POW_OVF_EN
    ,
    output logic              ovf
`endif
);

    localparam int unsigned CNT_W = $clog2(EXP_W + 1);
    localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(EXP_W - 1);

    typedef enum logic [1:0] {
        StIdle,
        StRun,
        StDone
    } state_e;

    state_e            state_q, state_d;
    logic [OUT_W-1:0]  base_q, base_d;
    logic [OUT_W-1:0]  result_q, result_d;
    logic [EXP_W-1:0]  e_q, e_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;

    logic [OUT_W-1:0]  sq;   // base * base, low OUT_W bits
    logic [OUT_W-1:0]  mul;  // result * base, low OUT_W bits

`ifdef POW_OVF_EN
    logic              base_big_q, base_big_d;
    logic              result_big_q, result_big_d;
    logic [2*OUT_W-1:0] sq_full;
    logic [2*OUT_W-1:0] mul_full;
    logic              sq_hi;
    logic              mul_hi;

    // Full-width products so the discarded upper half can flag overflow.
    assign sq_full  = (2*OUT_W)'(base_q) * (2*OUT_W)'(base_q);
    assign mul_full = (2*OUT_W)'(result_q) * (2*OUT_W)'(base_q);
    assign sq       = sq_full[OUT_W-1:0];
    assign mul      = mul_full[OUT_W-1:0];
    assign sq_hi    = |sq_full[2*OUT_W-1:OUT_W];
    assign mul_hi   = |mul_full[2*OUT_W-1:OUT_W];
`else
    assign sq  = base_q * base_q;
    assign mul = result_q * base_q;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= StIdle;
            base_q       <= '0;
            result_q     <= '0;
            e_q          <= '0;
            cnt_q        <= '0;
`ifdef POW_OVF_EN
            base_big_q   <= 1'b0;
            result_big_q <= 1'b0;
`endif
        end else begin
            state_q      <= state_d;
            base_q       <= base_d;
            result_q     <= result_d;
            e_q          <= e_d;
            cnt_q        <= cnt_d;
`ifdef POW_OVF_EN
            base_big_q   <= base_big_d;
            result_big_q <= result_big_d;
`endif
        end
    end

    always_comb begin
        state_d      = state_q;
        base_d       = base_q;
        result_d     = result_q;
        e_d          = e_q;
        cnt_d        = cnt_q;
`ifdef POW_OVF_EN
        base_big_d   = base_big_q;
        result_big_d = result_big_q;
`endif
        case (state_q)
            StIdle: begin
                if (data_in_valid) begin
                    base_d       = OUT_W'(data_in);
                    result_d     = OUT_W'(1);
                    e_d          = exp_in;
                    cnt_d        = '0;
`ifdef POW_OVF_EN
                    base_big_d   = 1'b0;
                    result_big_d = 1'b0;
`endif
                    state_d      = StRun;
                end
            end
            StRun: begin
                if (e_q[0]) begin
                    result_d = mul;
                end
                base_d = sq;
                e_d    = e_q >> 1;
                cnt_d  = cnt_q + CNT_W'(1);
`ifdef POW_OVF_EN
                base_big_d = base_big_q | sq_hi;
                // Multiplying by an already-overflowed base overflows the
                // true result even when the truncated product looks small.
                if (e_q[0]) begin
                    result_big_d = result_big_q | mul_hi | base_big_q;
                end
`endif
                // Fixed-length run: no early exit once e reaches zero.
                if (cnt_q == LAST_STEP) begin
                    state_d = StDone;
                end
            end
            StDone: begin
                if (data_out_ready) begin
                    state_d = StIdle;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    assign data_in_ready  = (state_q == StIdle);
    assign data_out_valid = (state_q == StDone);
    assign data_out       = (state_q == StDone) ? result_q : '0;
`ifdef POW_OVF_EN
    assign ovf            = (state_q == StDone) ? result_big_q : 1'b0;
`endif

endmodule

// File: tb/tb_pow_seq.sv
// Directed bench for pow_seq with default parameters (8/4/32).
module tb_pow_seq;

    localparam int unsigned DATA_W = 8;
    localparam int unsigned EXP_W  = 4;
    localparam int unsigned OUT_W  = 32;

    logic              clk = 1'b0;
    logic              rst;
    logic [DATA_W-1:0] data_in;
    logic [EXP_W-1:0]  exp_in;
    logic              data_in_valid;
    logic              data_in_ready;
    logic [OUT_W-1:0]  data_out;
    logic              data_out_valid;
    logic              data_out_ready;
`ifdef POW_OVF_EN
    logic              ovf;
`endif

    int n_total = 0;
    int n_bad   = 0;

    pow_seq #(
        .DATA_W(DATA_W),
        .EXP_W (EXP_W),
        .OUT_W (OUT_W)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .data_in       (data_in),
        .exp_in        (exp_in),
        .data_in_valid (data_in_valid),
        .data_in_ready (data_in_ready),
        .data_out      (data_out),
        .data_out_valid(data_out_valid),
        .data_out_ready(data_out_ready)
`ifdef POW_OVF_EN
        ,
        .ovf           (ovf)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Issue one operation from IDLE, hold the result for 'hold' cycles, then retire it.
    task automatic do_op(input string tag, input logic [7:0] p, input logic [3:0] q,
                         input logic [31:0] exp_v, input logic exp_ovf, input int hold);
        int cyc;
        logic [31:0] first;
        logic bad_hold;
        check({tag, "_in_rdy"}, 64'(data_in_ready), 64'(1));
        data_in       = p;
        exp_in        = q;
        data_in_valid = 1'b1;
        step();
        data_in_valid = 1'b0;
        cyc = 0;
        while (!data_out_valid && cyc < 20) begin
            step();
            cyc++;
        end
        check({tag, "_lat"}, 64'(cyc), 64'(EXP_W));
        check({tag, "_out"}, 64'(data_out), 64'(exp_v));
`ifdef POW_OVF_EN
        check({tag, "_ovf"}, 64'(ovf), 64'(exp_ovf));
`endif
        if (hold > 0) begin
            first    = data_out;
            bad_hold = 1'b0;
            // Offer a new operand while stalled; it must be ignored.
            data_in       = 8'd9;
            exp_in        = 4'd9;
            data_in_valid = 1'b1;
            for (int i = 0; i < hold; i++) begin
                step();
                if (!data_out_valid || data_out !== first || data_in_ready) bad_hold = 1'b1;
            end
            data_in_valid = 1'b0;
            check({tag, "_hold"}, 64'(bad_hold), 64'(0));
            check({tag, "_hold_out"}, 64'(data_out), 64'(exp_v));
        end
        data_out_ready = 1'b1;
        step();
        data_out_ready = 1'b0;
        check({tag, "_vld_low"}, 64'(data_out_valid), 64'(0));
        check({tag, "_out_zero"}, 64'(data_out), 64'(0));
        check({tag, "_idle"}, 64'(data_in_ready), 64'(1));
    endtask

    logic [7:0]  bb_p   [4] = '{8'd3, 8'd2, 8'd7, 8'd10};
    logic [3:0]  bb_q   [4] = '{4'd2, 4'd5, 4'd3, 4'd4};
    logic [31:0] bb_exp [4] = '{32'd9, 32'd32, 32'd343, 32'd10000};

    initial begin
        logic seen;
        int k;
        int j;
        rst            = 1'b1;
        data_in        = '0;
        exp_in         = '0;
        data_in_valid  = 1'b0;
        data_out_ready = 1'b0;
        step();
        step();
        check("rst_in_rdy", 64'(data_in_ready), 64'(1));
        check("rst_vld", 64'(data_out_valid), 64'(0));
        check("rst_out", 64'(data_out), 64'(0));
`ifdef POW_OVF_EN
        check("rst_ovf", 64'(ovf), 64'(0));
`endif
        rst = 1'b0;
        step();

        do_op("p3q4", 8'd3, 4'd4, 32'd81, 1'b0, 0);
        do_op("p0q0", 8'd0, 4'd0, 32'd1, 1'b0, 0);
        do_op("p2q0", 8'd2, 4'd0, 32'd1, 1'b0, 0);
        do_op("p0q5", 8'd0, 4'd5, 32'd0, 1'b0, 0);
        do_op("p1q15", 8'd1, 4'd15, 32'd1, 1'b0, 0);
        do_op("p255q4", 8'd255, 4'd4, 32'd4228250625, 1'b0, 0);
        do_op("p16q8", 8'd16, 4'd8, 32'd0, 1'b1, 0);
        do_op("p2q15", 8'd2, 4'd15, 32'd32768, 1'b0, 10);

        // Abort mid-run with reset: no result may ever appear.
        data_in       = 8'd3;
        exp_in        = 4'd4;
        data_in_valid = 1'b1;
        step();
        data_in_valid = 1'b0;
        step();
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("abort_idle", 64'(data_in_ready), 64'(1));
        seen = 1'b0;
        for (int i = 0; i < 6; i++) begin
            if (data_out_valid) seen = 1'b1;
            step();
        end
        check("abort_no_vld", 64'(seen), 64'(0));
        do_op("p5q3", 8'd5, 4'd3, 32'd125, 1'b0, 0);

        // Reset wins over a same-edge offer.
        rst           = 1'b1;
        data_in       = 8'd4;
        exp_in        = 4'd2;
        data_in_valid = 1'b1;
        step();
        rst           = 1'b0;
        data_in_valid = 1'b0;
        check("rst_vs_valid", 64'(data_in_ready), 64'(1));
        step();
        check("rst_vs_valid2", 64'(data_in_ready), 64'(1));

        // Back-to-back with valid and ready held high.
        k = 0;
        j = 0;
        data_out_ready = 1'b1;
        data_in        = bb_p[0];
        exp_in         = bb_q[0];
        data_in_valid  = 1'b1;
        for (int c = 0; c < 60; c++) begin
            logic acc;
            acc = data_in_valid && data_in_ready;
            if (data_out_valid) begin
                if (j < 4) check($sformatf("bb_out%0d", j), 64'(data_out), 64'(bb_exp[j]));
                else check("bb_extra", 64'(j), 64'(3));
                j++;
            end
            step();
            if (acc) k++;
            if (k < 4) begin
                data_in = bb_p[k];
                exp_in  = bb_q[k];
            end else begin
                data_in_valid = 1'b0;
            end
        end
        data_out_ready = 1'b0;
        check("bb_accepts", 64'(k), 64'(4));
        check("bb_results", 64'(j), 64'(4));

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
